// File: rtl/ntt_bank_addr_gen.sv
// Conflict-free lane address / bank-select generator for the 8-BFU radix-2 NTT.
// Optional ADDR_CONFLICT_CHECK_EN adds a per-beat bank-permutation checker.
module ntt_bank_addr_gen #(
    parameter int ADDR_WIDTH = 6,
    localparam int LOGN = ADDR_WIDTH + 4,
    localparam int SW   = $clog2(ADDR_WIDTH + 4)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  dir,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] b0, b1, b2, b3, b4, b5, b6, b7,
    output logic [ADDR_WIDTH-1:0] b8, b9, b10, b11, b12, b13, b14, b15,
    output logic [3:0]            sel_a_0, sel_a_1, sel_a_2, sel_a_3,
    output logic [3:0]            sel_a_4, sel_a_5, sel_a_6, sel_a_7,
    output logic [3:0]            sel_a_8, sel_a_9, sel_a_10, sel_a_11,
    output logic [3:0]            sel_a_12, sel_a_13, sel_a_14, sel_a_15,
    output logic [SW-1:0]         stage,
    output logic                  last,
    output logic                  busy,
    output logic                  done,
    output logic                  conflict_err
);
    localparam int CW = $clog2(ADDR_WIDTH);
    localparam int NS = (LOGN + 3) / 4;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t                state;
    logic [SW-1:0]         s_q;
    logic [ADDR_WIDTH-1:0] c_q;
    logic                  dir_q;
    logic [ADDR_WIDTH-1:0] b_q   [16];
    logic [3:0]            sel_q [16];

    logic [LOGN-1:0]       lane_idx  [16];
    logic [3:0]            lane_bank [16];
    logic [3:0]            sel_n     [16];
    logic                  beat_last, beat_load, start_acc;

    // Bit s carries lo/hi; the other three low-nibble bits (skipping s mod 4)
    // carry the BFU number; every remaining position takes the cycle count.
    function automatic logic [LOGN-1:0] make_idx(input logic [SW-1:0] s,
                                                 input logic [ADDR_WIDTH-1:0] c,
                                                 input logic [2:0] k, input logic hi);
        logic [LOGN-1:0] idx;
        logic [1:0]      kp;
        logic [CW-1:0]   cp;
        logic            bv;
        idx = '0;
        kp  = '0;
        cp  = '0;
        for (int p = 0; p < LOGN; p++) begin
            if (p == int'(s)) begin
                bv = hi;
            end else if (p < 4 && p != int'(s[1:0])) begin
                bv = k[kp];
                kp = kp + 2'd1;
            end else begin
                bv = c[cp];
                cp = cp + CW'(1);
            end
            idx = idx | (LOGN'(bv) << p);
        end
        return idx;
    endfunction

    function automatic logic [3:0] bank_of(input logic [LOGN-1:0] idx);
        logic [4*NS-1:0] w;
        logic [3:0]      bk;
        w  = (4*NS)'(idx);
        bk = '0;
        for (int j = 0; j < NS; j++) bk = bk ^ 4'(w >> (4*j));
        return bk;
    endfunction

    always_comb begin
        for (int l = 0; l < 16; l++) begin
            lane_idx[l]  = make_idx(s_q, c_q, 3'(l >> 1), 1'(l & 1));
            lane_bank[l] = bank_of(lane_idx[l]);
        end
        for (int n = 0; n < 16; n++) sel_n[n] = '0;
        for (int l = 0; l < 16; l++) sel_n[lane_bank[l]] = 4'(l);
    end

    assign beat_last = (s_q == (dir_q ? SW'(LOGN-1) : '0)) && (c_q == '1);
    assign start_acc = (state == ST_IDLE) && start;
    // s_q/c_q always point at the next beat to be registered onto the outputs.
    assign beat_load = (state == ST_RUN) && !(out_valid && out_ready && last)
                       && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            s_q       <= '0;
            c_q       <= '0;
            dir_q     <= 1'b0;
            out_valid <= 1'b0;
            stage     <= '0;
            last      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int l = 0; l < 16; l++) begin
                b_q[l]   <= '0;
                sel_q[l] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dir_q <= dir;
                        s_q   <= dir ? '0 : SW'(LOGN-1);
                        c_q   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (out_valid && out_ready && last) begin
                        out_valid <= 1'b0;
                        last      <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end else if (beat_load) begin
                        out_valid <= 1'b1;
                        stage     <= s_q;
                        last      <= beat_last;
                        for (int l = 0; l < 16; l++) begin
                            b_q[l]   <= lane_idx[l][LOGN-1:4];
                            sel_q[l] <= sel_n[l];
                        end
                        c_q <= c_q + 1'b1;
                        if (c_q == '1) s_q <= dir_q ? s_q + 1'b1 : s_q - 1'b1;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ADDR_CONFLICT_CHECK_EN
    logic [3:0]  bank_q [16];
    logic [15:0] seen;
    logic        chk_fail;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int l = 0; l < 16; l++) bank_q[l] <= '0;
        end else if (beat_load) begin
            for (int l = 0; l < 16; l++) bank_q[l] <= lane_bank[l];
        end
    end

    always_comb begin
        seen     = '0;
        chk_fail = 1'b0;
        for (int n = 0; n < 16; n++) begin
            seen = seen | (16'(1) << sel_q[n]);
            if (bank_q[sel_q[n]] != 4'(n)) chk_fail = 1'b1;
        end
        if (seen != '1) chk_fail = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || start_acc) conflict_err <= 1'b0;
        else if (out_valid && chk_fail) conflict_err <= 1'b1;
    end
`else
    assign conflict_err = 1'b0;
`endif

    assign b0  = b_q[0];   assign b1  = b_q[1];   assign b2  = b_q[2];   assign b3  = b_q[3];
    assign b4  = b_q[4];   assign b5  = b_q[5];   assign b6  = b_q[6];   assign b7  = b_q[7];
    assign b8  = b_q[8];   assign b9  = b_q[9];   assign b10 = b_q[10];  assign b11 = b_q[11];
    assign b12 = b_q[12];  assign b13 = b_q[13];  assign b14 = b_q[14];  assign b15 = b_q[15];
    assign sel_a_0  = sel_q[0];   assign sel_a_1  = sel_q[1];
    assign sel_a_2  = sel_q[2];   assign sel_a_3  = sel_q[3];
    assign sel_a_4  = sel_q[4];   assign sel_a_5  = sel_q[5];
    assign sel_a_6  = sel_q[6];   assign sel_a_7  = sel_q[7];
    assign sel_a_8  = sel_q[8];   assign sel_a_9  = sel_q[9];
    assign sel_a_10 = sel_q[10];  assign sel_a_11 = sel_q[11];
    assign sel_a_12 = sel_q[12];  assign sel_a_13 = sel_q[13];
    assign sel_a_14 = sel_q[14];  assign sel_a_15 = sel_q[15];

endmodule

// File: doc/ntt_bank_addr_gen.md
Name: ntt_bank_addr_gen

Overview:
- Conflict-free address and bank-select generator for the radix-2, 8-BFU NTT datapath. It sits directly upstream of the bank-input crossbar.
- Each beat it emits 16 lane addresses (lane 2k = BFU k low input, lane 2k+1 = high input) and, for every bank, the 4-bit index of the lane routed to it.
- It sequences all stages of one transform, with a valid/ready handshake toward the crossbar and memory stage.

Parameters:
- ADDR_WIDTH, 6, per-bank word address width. N = 16·2^ADDR_WIDTH. LOGN = ADDR_WIDTH+4 (index width and stage count).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to run a full transform; sampled only in IDLE.
- dir  in  1  0 = forward (stages LOGN-1 down to 0), 1 = inverse (stages 0 up to LOGN-1); latched on accepted start.
- out_ready  in  1  downstream accepts current beat.
- out_valid  out  1  beat valid.
- b0..b15  out  ADDR_WIDTH each  lane addresses.
- sel_a_0..sel_a_15  out  4 each  sel_a_n = lane whose index maps to bank n.
- stage  out  log2(LOGN) rounded up  stage of current beat.
- last  out  1  final beat of transform.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse after last beat accepted.
- conflict_err  out  1  sticky bank-conflict flag (see Optional Feature).

Behaviour:
- Clock and reset: one clock domain (clk); reset (rst) is synchronous and active-high.
- Reset: state = IDLE. All outputs are 0, including b*, sel_a_*, stage, conflict_err. Counters are 0.
- States:
  - IDLE: on start, latch dir, load stage = (dir ? 0 : LOGN-1), load cycle counter c = 0, go to RUN.
  - RUN: hold the beat while out_valid && !out_ready. On each accepted beat, increment c.
    - When c wraps from 2^ADDR_WIDTH-1, step the stage (+1 inverse, -1 forward).
    - After the accepted beat with last = 1, go to DONE.
  - DONE: done = 1 for one cycle, then IDLE.
- Start and timing:
  - start outside IDLE is ignored.
  - Latency: start sampled at edge T gives out_valid = 1 with the first beat after edge T+1 (registered outputs).
  - With out_ready held high, one beat per cycle. Total beats = LOGN·2^ADDR_WIDTH.
- Index generation for stage s, cycle c:
  - Varying bit set V = {s} ∪ ({0,1,2,3} minus {s mod 4}).
  - The three non-s varying bits, ascending position, take BFU number k[2:0].
  - The remaining LOGN-4 bit positions, ascending, take c[ADDR_WIDTH-1:0].
  - lo_k has bit s = 0; hi_k = lo_k | (1<<s).
- Address and bank mapping:
  - Address = index[LOGN-1:4].
  - Bank = XOR of index 4-bit slices, top slice zero-extended. This is conflict-free by construction.
  - sel_a_n = lane L with bank(index_L) = n.
- While stalled, all beat outputs stay stable. last = 1 only on the final stage's cycle 2^ADDR_WIDTH-1.
- Reset mid-RUN: return to IDLE next edge. No done pulse. Outputs are zeroed.

Optional Feature:
- ADDR_CONFLICT_CHECK_EN
- Defined: each emitted beat checks that sel_a_0..15 is a permutation of 0..15 and that each bank's selected lane actually maps to it. Any failure sets conflict_err. conflict_err clears only on rst or an accepted start.
- Undefined: conflict_err tied 0, no check logic.

Test Plan:
- Inverse, ADDR_WIDTH=6, ready high: first beat stage 0, c=0 -> lanes are indices 0..15, b0..b15 = 0, sel_a_n = n. Second beat -> indices 16..31, b* = 1, sel_a_n = n^1.
- Forward, ready high -> first beat stage 9; 640 valid beats; last on beat 640; done one cycle later; busy falls with done.
- out_ready low for 5 cycles mid-stage -> outputs frozen, no beat skipped or repeated. Scoreboard sees exactly 640 distinct (stage, c) pairs.
- Every beat, all stages -> each index 0..1023 appears exactly once per stage. hi − lo = 2^s. No bank conflict. conflict_err stays 0 when ADDR_CONFLICT_CHECK_EN is defined.
- rst asserted at beat 100 -> next cycle IDLE, all outputs 0, no done. start afterwards restarts from c = 0.
- start pulsed during RUN -> ignored, beat count unchanged.
